spi_rdout_module: RTL and testbench

- Transmit half of the SPI EEPROM slave: serializes array read data onto the serial output while the frame is in the data-read state.
- Fetches bytes from the memory array with a req/ack handshake, starting at the address assembled by the address-receive logic.
- Auto-increments the address per byte and keeps one-byte prefetch so consecutive bytes stream without gaps.
- spi_clk_c is the SCK edge on which the slave launches output data (the top level handles inversion).

---
 rtl/spi_rdout_module.sv | 153 +++++++++++++++
 tb/tb_spi_rdout_module.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rdout_module.sv
// Transmit half of the SPI EEPROM slave: fetches array bytes with one-byte prefetch
// and shifts them out MSB first while the frame is in the data-read state.
module spi_rdout_module #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              spi_clk_c,
    input  logic              spi_frm_rst_n,
    input  logic              spi_rd_en,
    input  logic              spi_rd_start,
    input  logic [ADDR_W-1:0] spi_start_addr,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              spi_sdo,
    output logic              spi_sdo_oe,
    output logic              spi_byte_done,
    output logic              spi_rd_underrun
);

    localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CntW-1:0] CntTop = CntW'(DATA_W - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch0,
        StStream
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              buf_valid_q, buf_valid_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic              oe_q, oe_d;
    logic              byte_done_q, byte_done_d;
    logic              underrun_q, underrun_d;

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        req_d       = req_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        oe_d        = oe_q;
        byte_done_d = 1'b0;
        underrun_d  = underrun_q;

        if (!spi_rd_en) begin
            // Leaving the data-read state: drop everything, idle the pad high.
            state_d     = StIdle;
            req_d       = 1'b0;
            oe_d        = 1'b0;
            shreg_d     = '1;
            buf_valid_d = 1'b0;
            bit_cnt_d   = '0;
        end else if (spi_rd_start) begin
            // A restart keeps req low for one cycle so the address can change safely.
            state_d     = StFetch0;
            rd_addr_d   = spi_start_addr;
            req_d       = (state_q == StIdle);
            oe_d        = 1'b0;
            shreg_d     = '1;
            buf_valid_d = 1'b0;
            bit_cnt_d   = '0;
        end else begin
            if (req_q && mem_rd_ack) begin
                buf_d       = mem_rd_data;
                buf_valid_d = 1'b1;
                req_d       = 1'b0;
                rd_addr_d   = rd_addr_q + ADDR_W'(1);
            end

            case (state_q)
                StFetch0: begin
                    if (buf_valid_q) begin
                        shreg_d     = buf_q;
                        oe_d        = 1'b1;
                        buf_valid_d = 1'b0;
                        bit_cnt_d   = CntTop;
                        req_d       = 1'b1;
                        state_d     = StStream;
                    end else if (!req_q) begin
                        req_d = 1'b1;
                    end
                end
                StStream: begin
                    if (bit_cnt_q != '0) begin
                        shreg_d     = {shreg_q[DATA_W-2:0], 1'b1};
                        bit_cnt_d   = bit_cnt_q - CntOne;
                        byte_done_d = (bit_cnt_q == CntOne);
                    end else begin
                        bit_cnt_d = CntTop;
                        if (buf_valid_q) begin
                            shreg_d     = buf_q;
                            buf_valid_d = 1'b0;
                            req_d       = 1'b1;
                        end else begin
                            // Outstanding fetch stays pending; its byte goes out next slot.
                            shreg_d    = '1;
                            underrun_d = 1'b1;
                        end
                    end
                end
                StIdle: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge spi_clk_c or negedge spi_frm_rst_n) begin
        if (!spi_frm_rst_n) begin
            state_q     <= StIdle;
            rd_addr_q   <= '0;
            req_q       <= 1'b0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            shreg_q     <= '1;
            bit_cnt_q   <= '0;
            oe_q        <= 1'b0;
            byte_done_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            req_q       <= req_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            oe_q        <= oe_d;
            byte_done_q <= byte_done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign mem_rd_req      = req_q;
    assign mem_rd_addr     = rd_addr_q;
    assign spi_sdo         = shreg_q[DATA_W-1];
    assign spi_sdo_oe      = oe_q;
    assign spi_byte_done   = byte_done_q;
    assign spi_rd_underrun = underrun_q;

endmodule

// File: tb/tb_spi_rdout_module.sv
// Bench for spi_rdout_module: directed scenarios plus random sessions, checked every
// cycle against a byte-queue model of the read stream.
module tb_spi_rdout_module;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en;
    logic        rd_start;
    logic [15:0] start_addr;
    logic        ack;
    logic [7:0]  rdata;
    logic        mem_rd_req;
    logic [15:0] mem_rd_addr;
    logic        sdo;
    logic        oe;
    logic        bdone;
    logic        under;

    always #5 clk = ~clk;

    spi_rdout_module #(
        .ADDR_W(16),
        .DATA_W(8)
    ) dut (
        .spi_clk_c      (clk),
        .spi_frm_rst_n  (rst_n),
        .spi_rd_en      (rd_en),
        .spi_rd_start   (rd_start),
        .spi_start_addr (start_addr),
        .mem_rd_req     (mem_rd_req),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_ack     (ack),
        .mem_rd_data    (rdata),
        .spi_sdo        (sdo),
        .spi_sdo_oe     (oe),
        .spi_byte_done  (bdone),
        .spi_rd_underrun(under)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  mem [0:65535];
    int          wait_cnt, cur_delay, fetch_no, slow_idx, max_delay;
    logic [23:0] shift_mon;

    // Model: 0 idle, 1 waiting for first byte, 2 streaming.
    int          m_state;
    bit          m_gap;
    logic [15:0] m_base;
    int          m_nacks;
    logic [7:0]  m_q[$];
    logic [7:0]  m_cur;
    int          m_pos;
    bit          m_under;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    function automatic int pick_delay();
        if (fetch_no == slow_idx) return 10;
        return int'($urandom_range(max_delay, 0));
    endfunction

    function automatic bit exp_req();
        return (m_state != 0) && !m_gap && (m_q.size() == 0);
    endfunction

    function automatic logic exp_sdo();
        return (m_state == 2) ? m_cur[7-m_pos] : 1'b1;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_gap   = 1'b0;
        m_q.delete();
        m_nacks = 0;
        m_pos   = 0;
        m_under = 1'b0;
    endtask

    task automatic model_edge(input bit en, input bit st, input logic [15:0] sa,
                              input bit taken, input logic [7:0] d);
        bit have;
        if (!en) begin
            m_state = 0;
            m_gap   = 1'b0;
            m_q.delete();
        end else if (st) begin
            m_gap   = (m_state != 0);
            m_state = 1;
            m_base  = sa;
            m_nacks = 0;
            m_q.delete();
        end else begin
            have = (m_q.size() != 0);
            if (m_state == 1) begin
                m_gap = 1'b0;
                if (have) begin
                    m_cur   = m_q.pop_front();
                    m_pos   = 0;
                    m_state = 2;
                end
            end else if (m_state == 2) begin
                if (m_pos < 7) begin
                    m_pos++;
                end else begin
                    m_pos = 0;
                    if (have) begin
                        m_cur = m_q.pop_front();
                    end else begin
                        m_cur   = 8'hFF;
                        m_under = 1'b1;
                    end
                end
            end
            if (taken) begin
                m_q.push_back(d);
                m_nacks++;
            end
        end
    endtask

    // One clock: check outputs, answer the memory port, drive inputs, advance the model.
    task automatic step(input bit en, input bit st, input logic [15:0] sa, input bit fack);
        bit          r;
        logic [15:0] ea;
        @(negedge clk);
        r  = exp_req();
        ea = m_base + 16'(m_nacks);
        check("req", 32'(mem_rd_req), 32'(r));
        if (r) check("addr", 32'(mem_rd_addr), 32'(ea));
        check("oe", 32'(oe), 32'(m_state == 2));
        check("sdo", 32'(sdo), 32'(exp_sdo()));
        check("byte_done", 32'(bdone), 32'((m_state == 2) && (m_pos == 7)));
        check("underrun", 32'(under), 32'(m_under));
        if (oe) shift_mon = {shift_mon[22:0], sdo};

        ack   = 1'b0;
        rdata = 8'($urandom);
        if (mem_rd_req) begin
            wait_cnt++;
            if (wait_cnt > cur_delay) begin
                ack      = 1'b1;
                rdata    = mem[mem_rd_addr];
                wait_cnt = 0;
                fetch_no++;
                cur_delay = pick_delay();
            end
        end else begin
            wait_cnt = 0;
            if ($urandom_range(3, 0) == 0) ack = 1'b1;
        end
        if (fack) ack = 1'b1;

        rd_en      = en;
        rd_start   = st;
        start_addr = sa;
        model_edge(en, st, sa, r && ack, rdata);
    endtask

    task automatic session_init(input int mdel, input int slow);
        max_delay = mdel;
        slow_idx  = slow;
        fetch_no  = 0;
        wait_cnt  = 0;
        cur_delay = pick_delay();
        shift_mon = '0;
    endtask

    initial begin
        logic [15:0] a;
        int          len;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst_n = 1'b0; rd_en = 1'b0; rd_start = 1'b0; start_addr = '0;
        ack = 1'b0; rdata = '0;
        model_reset();
        m_base = '0;
        session_init(0, -1);

        #12;
        check("rst_req", 32'(mem_rd_req), 32'd0);
        check("rst_addr", 32'(mem_rd_addr), 32'd0);
        check("rst_sdo", 32'(sdo), 32'd1);
        check("rst_oe", 32'(oe), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single byte
        mem[16'h0120] = 8'hA5;
        session_init(0, -1);
        step(1'b1, 1'b1, 16'h0120, 1'b0);
        repeat (10) step(1'b1, 1'b0, 16'h0, 1'b0);
        check("t1_byte", 32'(shift_mon[7:0]), 32'hA5);
        repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);

        // Stream across the address wrap
        mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22; mem[16'h0000] = 8'h33;
        session_init(0, -1);
        step(1'b1, 1'b1, 16'hFFFE, 1'b0);
        repeat (26) step(1'b1, 1'b0, 16'h0, 1'b0);
        check("t2_stream", 32'(shift_mon), 32'h112233);
        step(1'b0, 1'b0, 16'h0, 1'b0);

        // Slow second fetch -> filler byte, then the delayed byte
        a = 16'($urandom);
        session_init(0, 1);
        step(1'b1, 1'b1, a, 1'b0);
        repeat (26) step(1'b1, 1'b0, 16'h0, 1'b0);
        check("t3_stream", 32'(shift_mon), 32'({mem[a], 8'hFF, mem[16'(a + 16'd1)]}));
        check("t3_under", 32'(under), 32'd1);
        step(1'b0, 1'b0, 16'h0, 1'b0);

        // Abort mid-byte, then a late ack
        session_init(3, -1);
        step(1'b1, 1'b1, 16'($urandom), 1'b0);
        repeat (8) step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0);
        check("t4_oe", 32'(oe), 32'd0);

        // Restart mid-stream with a coincident ack
        session_init(0, -1);
        step(1'b1, 1'b1, 16'($urandom), 1'b0);
        repeat (13) step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'h0040, 1'b1);
        repeat (20) step(1'b1, 1'b0, 16'h0, 1'b0);

        // Async reset mid-byte while the prefetch is outstanding
        session_init(0, 1);
        step(1'b1, 1'b1, 16'($urandom), 1'b0);
        repeat (6) step(1'b1, 1'b0, 16'h0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_req", 32'(mem_rd_req), 32'd0);
        check("t6_oe", 32'(oe), 32'd0);
        check("t6_under", 32'(under), 32'd0);
        check("t6_bdone", 32'(bdone), 32'd0);
        check("t6_sdo", 32'(sdo), 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        wait_cnt = 0;
        step(1'b1, 1'b0, 16'h0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0);

        // Random sessions
        for (int s = 0; s < 40; s++) begin
            session_init(int'($urandom_range(12, 0)), -1);
            step(1'b1, 1'b1, 16'($urandom), 1'b0);
            len = int'($urandom_range(60, 10));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(49, 0) == 0)
                    step(1'b1, 1'b1, 16'($urandom), 1'($urandom_range(1, 0)));
                else
                    step(1'b1, 1'b0, 16'h0, 1'b0);
            end
            step(1'b0, 1'($urandom_range(1, 0)), 16'($urandom), 1'($urandom_range(1, 0)));
            step(1'b1, 1'b0, 16'h0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
